mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester (CPU datapath / debug loader) arbiter in front
//                of a single-port memory with a fixed read latency. Requests
//                are sampled only while idle. Simultaneous requests are
//                resolved round-robin. Each granted access runs for MEM_LAT
//                cycles and then gives a one-cycle Done pulse to its owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  // Memory read latency in cycles; legal range 1..7 (fits the 3-bit counter).
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,        // asynchronous, active-low

  // CPU datapath requester
  input  logic        Cpu_Req,
  input  logic        Cpu_Wr,
  input  logic [31:0] Cpu_Addr,
  input  logic [31:0] Cpu_WData,
  output logic        Cpu_Done,
  output logic        Cpu_Stall,

  // Debug loader requester
  input  logic        Ldr_Req,
  input  logic        Ldr_Wr,
  input  logic [31:0] Ldr_Addr,
  input  logic [31:0] Ldr_WData,
  input  logic        Ldr_En,
  output logic        Ldr_Done,

  // Shared read data
  output logic [31:0] RData,

  // Memory port
  output logic [31:0] Mem_Address,
  output logic        Mem_Wr,
  output logic [31:0] Mem_Datain,
  input  logic [31:0] Mem_Dataout,

  output logic        Busy
);

  // Counter load value; the counter counts MEM_LAT..1 across the ACCESS phase.
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic        last_q,  last_d;   // 1 = loader was granted last, 0 = CPU
  logic        gnt_q,   gnt_d;    // 1 = current grant belongs to the loader
  logic        wr_q,    wr_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cpu_elig;
  logic        ldr_elig;
  logic        pick_ldr;

  // A disabled loader is invisible to the arbiter.
  assign cpu_elig = Cpu_Req;
  assign ldr_elig = Ldr_Req & Ldr_En;

  // Loader wins when it is the only eligible requester, or on a tie when the
  // CPU was served last.
  assign pick_ldr = ldr_elig & (~cpu_elig | ~last_q);

  // Next-state, grant latching, latency counting and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_elig | ldr_elig) begin
          gnt_d   = pick_ldr;
          last_d  = pick_ldr;
          wr_d    = pick_ldr ? Ldr_Wr    : Cpu_Wr;
          addr_d  = pick_ldr ? Ldr_Addr  : Cpu_Addr;
          wdata_d = pick_ldr ? Ldr_WData : Cpu_WData;
          cnt_d   = LAT_LOAD;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          // Memory data is valid in the final ACCESS cycle; writes leave
          // RData untouched.
          if (!wr_q) begin
            rdata_d = Mem_Dataout;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves the loader as "last" so the
  // CPU wins the first tie.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The latched address/data stay on the memory port between accesses.
  assign Mem_Address = addr_q;
  assign Mem_Datain  = wdata_q;

  // The write strobe is limited to the first ACCESS cycle (counter still at
  // its load value) so each write lands exactly once.
  assign Mem_Wr = (state_q == ACCESS) & wr_q & (cnt_q == LAT_LOAD);

  assign Busy      = (state_q != IDLE);
  assign Cpu_Done  = (state_q == RESP) & ~gnt_q;
  assign Ldr_Done  = (state_q == RESP) &  gnt_q;
  assign Cpu_Stall = Cpu_Req & ~Cpu_Done;
  assign RData     = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Two instances
//                (MEM_LAT = 1 and MEM_LAT = 3) each run directed scenarios
//                followed by randomized traffic, compared every cycle against
//                a transaction-level model with a behavioural memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit fin [2];

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (inst %0d) actual=0x%08h required=0x%08h at %0t",
               name, inst, act, exp, $time);
    end
  endtask

  // Content of a memory word that has never been written.
  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 3;

      logic        rst_n;
      logic        cpu_req, cpu_wr, ldr_req, ldr_wr, ldr_en;
      logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
      logic        cpu_done, ldr_done, cpu_stall, mem_wr, busy;
      logic [31:0] rdata, mem_addr, mem_din;
      logic [31:0] mem_dout = 32'd0;

      mem_arbiter #(.MEM_LAT(LAT)) u_dut (
        .Clk        (clk),
        .Reset      (rst_n),
        .Cpu_Req    (cpu_req),
        .Cpu_Wr     (cpu_wr),
        .Cpu_Addr   (cpu_addr),
        .Cpu_WData  (cpu_wdata),
        .Cpu_Done   (cpu_done),
        .Cpu_Stall  (cpu_stall),
        .Ldr_Req    (ldr_req),
        .Ldr_Wr     (ldr_wr),
        .Ldr_Addr   (ldr_addr),
        .Ldr_WData  (ldr_wdata),
        .Ldr_En     (ldr_en),
        .Ldr_Done   (ldr_done),
        .RData      (rdata),
        .Mem_Address(mem_addr),
        .Mem_Wr     (mem_wr),
        .Mem_Datain (mem_din),
        .Mem_Dataout(mem_dout),
        .Busy       (busy)
      );

      // ---------------- reference model ----------------
      // k = cycles since the grant: 0 idle, 1..LAT memory access, LAT+1 done.
      int          k        = 0;
      bit          who_ldr  = 1'b0;
      bit          last_ldr = 1'b1;
      bit          m_wr     = 1'b0;
      logic [31:0] m_addr   = 32'd0;
      logic [31:0] m_wdata  = 32'd0;
      logic [31:0] m_rdata  = 32'd0;
      logic [31:0] mem [bit [31:0]];

      function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return mem_init(a);
      endfunction

      initial begin : p_model
        bit ce, le;
        forever begin
          @(posedge clk or negedge rst_n);
          if (!rst_n) begin
            k = 0; last_ldr = 1'b1; who_ldr = 1'b0; m_wr = 1'b0;
            m_addr = 32'd0; m_wdata = 32'd0; m_rdata = 32'd0;
            mem_dout <= $urandom;
          end else begin
            if (k != 0) begin
              if (k == 1 && m_wr) mem[m_addr] = m_wdata;
              if (k == LAT && !m_wr) m_rdata = mem_dout;
              k = (k == LAT + 1) ? 0 : k + 1;
            end else begin
              ce = cpu_req;
              le = ldr_req && ldr_en;
              if (ce || le) begin
                who_ldr  = (ce && le) ? !last_ldr : le;
                last_ldr = who_ldr;
                m_wr     = who_ldr ? ldr_wr    : cpu_wr;
                m_addr   = who_ldr ? ldr_addr  : cpu_addr;
                m_wdata  = who_ldr ? ldr_wdata : cpu_wdata;
                k = 1;
              end
            end
            // Memory output is only meaningful in the capture cycle; drive
            // noise otherwise so a mistimed capture is visible.
            mem_dout <= (k == LAT && !m_wr) ? mem_val(m_addr) : $urandom;
          end
        end
      end

      // Per-cycle comparison of every DUT output against the model.
      initial begin : p_compare
        forever begin
          @(negedge clk);
          check("busy",      gi, busy,      k != 0);
          check("mem_wr",    gi, mem_wr,    (k == 1) && m_wr);
          check("mem_addr",  gi, mem_addr,  m_addr);
          check("mem_din",   gi, mem_din,   m_wdata);
          check("cpu_done",  gi, cpu_done,  (k == LAT + 1) && !who_ldr);
          check("ldr_done",  gi, ldr_done,  (k == LAT + 1) && who_ldr);
          check("rdata",     gi, rdata,     m_rdata);
          check("cpu_stall", gi, cpu_stall, cpu_req && !((k == LAT + 1) && !who_ldr));
        end
      end

      // ---------------- stimulus ----------------
      task automatic cyc();
        @(posedge clk);
        #1;
      endtask

      task automatic idle_all();
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        ldr_req = 1'b0; ldr_wr = 1'b0; ldr_addr = 32'd0; ldr_wdata = 32'd0;
      endtask

      task automatic do_reset();
        rst_n = 1'b0;
        idle_all();
        repeat (2) cyc();
        rst_n = 1'b1;
      endtask

      initial begin : p_stim
        int n, c, nwr, bad, rst_cyc;
        bit seq [4];
        int at  [4];
        logic cd, ld;
        bit cpu_pend, ldr_pend;

        rst_n = 1'b0;
        idle_all();
        ldr_en = 1'b1;
        mem[32'h10] = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        check("reset busy",     gi, busy,     1'b0);
        check("reset mem_addr", gi, mem_addr, 32'd0);
        check("reset rdata",    gi, rdata,    32'd0);
        check("reset mem_wr",   gi, mem_wr,   1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // A: CPU read of 0x10 returning 0xDEADBEEF
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h10;
        @(negedge clk);
        check("A stall c0", gi, cpu_stall, 1'b1);
        for (int i = 1; i <= LAT + 1; i++) begin
          @(negedge clk);
          if (i <= LAT) begin
            check("A stall", gi, cpu_stall, 1'b1);
            check("A done early", gi, cpu_done, 1'b0);
          end else begin
            check("A done", gi, cpu_done, 1'b1);
            check("A rdata", gi, rdata, 32'hDEADBEEF);
          end
        end
        cyc();
        cpu_req = 1'b0;
        @(negedge clk);
        check("A idle after", gi, busy, 1'b0);

        // B: both requesters held high -> C, L, C, L every LAT+2 cycles
        do_reset();
        ldr_en = 1'b1;
        cpu_req = 1'b1; cpu_addr = 32'h30;
        ldr_req = 1'b1; ldr_addr = 32'h40;
        n = 0; c = 0;
        while (n < 4 && c < 4 * (LAT + 2) + 8) begin
          @(negedge clk);
          c++;
          if (cpu_done || ldr_done) begin
            seq[n] = ldr_done;
            at[n]  = c;
            n++;
          end
        end
        cyc();
        cpu_req = 1'b0; ldr_req = 1'b0;
        check("B done count", gi, n, 4);
        for (int i = 0; i < n; i++) begin
          check("B grant order", gi, seq[i], i % 2);
          if (i > 0) check("B done spacing", gi, at[i] - at[i-1], LAT + 2);
        end

        // C: loader write 0x12345678 to 0x20
        @(negedge clk);
        ldr_wr = 1'b1; ldr_addr = 32'h20; ldr_wdata = 32'h12345678;
        cyc();
        ldr_req = 1'b1;
        nwr = 0;
        for (int i = 0; i <= LAT + 1; i++) begin
          @(negedge clk);
          if (mem_wr) begin
            nwr++;
            check("C wr cycle", gi, i, 1);
            check("C wr addr", gi, mem_addr, 32'h20);
            check("C wr data", gi, mem_din, 32'h12345678);
          end
          if (i == LAT + 1) check("C ldr_done", gi, ldr_done, 1'b1);
        end
        cyc();
        ldr_req = 1'b0; ldr_wr = 1'b0;
        check("C wr pulses", gi, nwr, 1);
        @(negedge clk);
        check("C rdata kept", gi, rdata, mem_init(32'h40));

        // D: disabled loader is ignored; CPU still served
        cyc();
        ldr_en = 1'b0; ldr_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (busy || ldr_done) bad++;
        end
        check("D loader ignored", gi, bad, 0);
        cyc();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h20;
        for (int i = 0; i <= LAT + 1; i++) begin
          @(negedge clk);
          if (i == LAT + 1) begin
            check("D cpu_done", gi, cpu_done, 1'b1);
            check("D rdata", gi, rdata, 32'h12345678);
            check("D no ldr_done", gi, ldr_done, 1'b0);
          end
        end
        cyc();
        cpu_req = 1'b0; ldr_req = 1'b0; ldr_en = 1'b1;

        // E: reset in the middle of a CPU write
        rst_cyc = (LAT >= 2) ? 2 : 1;
        cyc();
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'hCAFEF00D;
        for (int i = 0; i < rst_cyc; i++) cyc();
        check("E busy before", gi, busy, 1'b1);
        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_wr = 1'b0;
        #1;
        check("E busy reset", gi, busy, 1'b0);
        check("E mem_wr reset", gi, mem_wr, 1'b0);
        check("E mem_addr reset", gi, mem_addr, 32'd0);
        repeat (2) cyc();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (cpu_done || busy) bad++;
        end
        check("E no done after reset", gi, bad, 0);
        cyc();
        cpu_req = 1'b1; cpu_addr = 32'h50;
        for (int i = 0; i <= LAT + 1; i++) begin
          @(negedge clk);
          check("E post-reset done", gi, cpu_done, i == LAT + 1);
        end
        cyc();
        cpu_req = 1'b0;

        // Random traffic
        cpu_pend = 1'b0; ldr_pend = 1'b0;
        for (int i = 0; i < 1500; i++) begin
          @(negedge clk);
          cd = cpu_done; ld = ldr_done;
          cyc();
          if (cpu_pend && cd) cpu_pend = 1'b0;
          if (!cpu_pend) begin
            if ($urandom_range(0, 2) == 0) begin
              cpu_pend = 1'b1; cpu_req = 1'b1; cpu_wr = 1'($urandom_range(0, 1));
              cpu_addr = $urandom_range(0, 15); cpu_wdata = $urandom;
            end else begin
              cpu_req = 1'b0;
            end
          end else if ($urandom_range(0, 49) == 0) begin
            cpu_req = 1'b0; cpu_pend = 1'b0;
          end
          if (ldr_pend && ld) ldr_pend = 1'b0;
          if (!ldr_pend) begin
            if ($urandom_range(0, 2) == 0) begin
              ldr_pend = 1'b1; ldr_req = 1'b1; ldr_wr = 1'($urandom_range(0, 1));
              ldr_addr = $urandom_range(0, 15); ldr_wdata = $urandom;
            end else begin
              ldr_req = 1'b0;
            end
          end else if ($urandom_range(0, 49) == 0) begin
            ldr_req = 1'b0; ldr_pend = 1'b0;
          end
          if ($urandom_range(0, 9) == 0) ldr_en = ~ldr_en;
        end
        idle_all();
        repeat (LAT + 4) cyc();
        fin[gi] = 1'b1;
      end
    end
  endgenerate

  initial begin : p_summary
    int c;
    c = 0;
    while (!(fin[0] && fin[1]) && c < 20000) begin
      @(posedge clk);
      c++;
    end
    if (!(fin[0] && fin[1])) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: stimulus did not complete within %0d cycles", c);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
